// File: rtl/virtio_available_ring_unpacker_if.sv
// Stream bundle for the available-ring unpacker: packed ring words in,
// one descriptor head per transfer out, plus per-queue consumption counters.
interface virtio_available_ring_unpacker_if #(
  parameter int unsigned QUEUES = 4
);
  logic                   rx_tvalid;
  logic                   rx_tready;
  logic [3:0][7:0]        rx_tdata;
  logic [3:0]             rx_tkeep;
  logic                   rx_tlast;
  logic [1:0]             rx_tid;
  logic                   tx_tvalid;
  logic                   tx_tready;
  logic [1:0][7:0]        tx_tdata;
  logic                   tx_tlast;
  logic                   tx_tuser;
  logic [1:0]             tx_tid;
  logic [QUEUES-1:0][15:0] consumed_idx;
  logic                   keep_error;

  modport slave (
    input  rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tid, tx_tready,
    output rx_tready, tx_tvalid, tx_tdata, tx_tlast, tx_tuser, tx_tid,
           consumed_idx, keep_error
  );

  modport master (
    output rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tid, tx_tready,
    input  rx_tready, tx_tvalid, tx_tdata, tx_tlast, tx_tuser, tx_tid,
           consumed_idx, keep_error
  );
endinterface

// File: rtl/virtio_available_ring_unpacker.sv
// Splits 32-bit available-ring words (two 16-bit heads) into single descriptor
// heads, flags out-of-range indices and counts consumed heads per virtqueue.
module virtio_available_ring_unpacker #(
  parameter int unsigned QUEUE_SIZE = 256,
  parameter int unsigned QUEUES     = 4
) (
  input  logic aclk,
  input  logic areset_n,
  virtio_available_ring_unpacker_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, LOW, HIGH} state_t;

  localparam logic [16:0] QUEUE_SIZE_17 = 17'(QUEUE_SIZE);

  state_t      state_reg, state_next;
  logic [31:0] data_reg;
  logic        hi_vld_reg;
  logic        last_reg;
  logic [1:0]  tid_reg;
  logic        run_reg;
  logic        keep_error_reg;
  logic [QUEUES-1:0][15:0] consumed_reg;

  logic        lo_ok, hi_ok, keep_bad;
  logic        is_last_half;
  logic        tx_valid, tx_hs, rx_ready, rx_hs;
  logic [15:0] cur_idx;
  logic        tid_bad;

  // A half counts only when both of its byte qualifiers are present.
  assign lo_ok    = bus.rx_tkeep[0] & bus.rx_tkeep[1];
  assign hi_ok    = bus.rx_tkeep[2] & bus.rx_tkeep[3];
  assign keep_bad = (bus.rx_tkeep[0] ^ bus.rx_tkeep[1]) |
                    (bus.rx_tkeep[2] ^ bus.rx_tkeep[3]);

  assign tid_bad  = (32'(tid_reg) >= QUEUES);
  assign cur_idx  = (state_reg == HIGH) ? data_reg[31:16] : data_reg[15:0];

  always_comb begin
    state_next   = state_reg;
    tx_valid     = (state_reg == LOW) || (state_reg == HIGH);
    is_last_half = (state_reg == HIGH) || ((state_reg == LOW) && !hi_vld_reg);
    tx_hs        = tx_valid && bus.tx_tready;
    // run_reg holds off acceptance until the first edge after reset release.
    rx_ready     = run_reg && ((state_reg == EMPTY) || (tx_hs && is_last_half));
    rx_hs        = bus.rx_tvalid && rx_ready;

    if (rx_hs) begin
      if (lo_ok)      state_next = LOW;
      else if (hi_ok) state_next = HIGH;
      else            state_next = EMPTY;
    end else if (tx_hs) begin
      if ((state_reg == LOW) && hi_vld_reg) state_next = HIGH;
      else                                  state_next = EMPTY;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg      <= EMPTY;
      data_reg       <= '0;
      hi_vld_reg     <= 1'b0;
      last_reg       <= 1'b0;
      tid_reg        <= '0;
      run_reg        <= 1'b0;
      keep_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      run_reg        <= 1'b1;
      keep_error_reg <= rx_hs && keep_bad;
      if (rx_hs) begin
        data_reg   <= bus.rx_tdata;
        hi_vld_reg <= hi_ok;
        last_reg   <= bus.rx_tlast;
        tid_reg    <= bus.rx_tid;
      end
    end
  end

  // Counters wrap naturally at 16 bits, matching virtio last_avail_idx.
  for (genvar gi = 0; gi < QUEUES; gi++) begin : g_queue
    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n)
        consumed_reg[gi] <= '0;
      else if (tx_hs && !tid_bad && (32'(tid_reg) == gi))
        consumed_reg[gi] <= consumed_reg[gi] + 16'd1;
    end
  end

  assign bus.rx_tready    = rx_ready;
  assign bus.tx_tvalid    = tx_valid;
  assign bus.tx_tdata     = cur_idx;
  assign bus.tx_tlast     = tx_valid && last_reg && is_last_half;
  assign bus.tx_tuser     = tx_valid && (({1'b0, cur_idx} >= QUEUE_SIZE_17) || tid_bad);
  assign bus.tx_tid       = tid_reg;
  assign bus.consumed_idx = consumed_reg;
  assign bus.keep_error   = keep_error_reg;

endmodule

// File: tb/tb_virtio_available_ring_unpacker.sv
// Directed bench for the available-ring unpacker: hand-computed heads,
// flags, handshakes and per-queue counters checked with immediate assertions.
module tb_virtio_available_ring_unpacker;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  virtio_available_ring_unpacker_if #(.QUEUES(4)) bus ();

  virtio_available_ring_unpacker #(.QUEUE_SIZE(256), .QUEUES(4)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic [1:0] t);
    bus.rx_tvalid = v;
    bus.rx_tdata  = d;
    bus.rx_tkeep  = k;
    bus.rx_tlast  = l;
    bus.rx_tid    = t;
    #1;
  endtask

  initial begin
    bus.tx_tready = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);

    // Reset values
    repeat (3) tick();
    check("rst_rx_tready", 32'(bus.rx_tready), 32'd0);
    check("rst_tx_tvalid", 32'(bus.tx_tvalid), 32'd0);
    check("rst_tx_tdata", 32'(bus.tx_tdata), 32'd0);
    check("rst_keep_error", 32'(bus.keep_error), 32'd0);
    check("rst_consumed2", 32'(bus.consumed_idx[2]), 32'd0);
    areset_n = 1'b1;
    #1;
    check("rel_rx_tready_held", 32'(bus.rx_tready), 32'd0);
    tick();
    check("rel_rx_tready_up", 32'(bus.rx_tready), 32'd1);

    // Double-entry beat, tid 2
    drive(1'b1, 32'h0005_0003, 4'hF, 1'b1, 2'd2);
    check("d_rx_ready_in", 32'(bus.rx_tready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    check("d_lo_data", 32'(bus.tx_tdata), 32'h0003);
    check("d_lo_valid", 32'(bus.tx_tvalid), 32'd1);
    check("d_lo_last", 32'(bus.tx_tlast), 32'd0);
    check("d_lo_tid", 32'(bus.tx_tid), 32'd2);
    check("d_lo_rx_ready", 32'(bus.rx_tready), 32'd0);
    tick();
    check("d_hi_data", 32'(bus.tx_tdata), 32'h0005);
    check("d_hi_last", 32'(bus.tx_tlast), 32'd1);
    check("d_hi_rx_ready", 32'(bus.rx_tready), 32'd1);
    tick();
    check("d_idle_valid", 32'(bus.tx_tvalid), 32'd0);
    check("d_consumed2", 32'(bus.consumed_idx[2]), 32'd2);

    // Back-to-back single-entry beats, no bubble
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 4'h3, (i == 3), 2'd0);
      check($sformatf("b2b_rx_ready_%0d", i), 32'(bus.rx_tready), 32'd1);
      tick();
      check($sformatf("b2b_data_%0d", i), 32'(bus.tx_tdata), 32'(i));
      check($sformatf("b2b_last_%0d", i), 32'(bus.tx_tlast), 32'(i == 3));
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    tick();
    check("b2b_consumed0", 32'(bus.consumed_idx[0]), 32'd3);

    // Range check at QUEUE_SIZE boundary
    drive(1'b1, 32'h00FF_0100, 4'hF, 1'b0, 2'd1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    check("range_0100_data", 32'(bus.tx_tdata), 32'h0100);
    check("range_0100_user", 32'(bus.tx_tuser), 32'd1);
    tick();
    check("range_00ff_data", 32'(bus.tx_tdata), 32'h00FF);
    check("range_00ff_user", 32'(bus.tx_tuser), 32'd0);
    tick();

    // Partial keep on upper half
    drive(1'b1, 32'hAB07_0009, 4'h7, 1'b1, 2'd3);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    check("keep_data", 32'(bus.tx_tdata), 32'h0009);
    check("keep_last", 32'(bus.tx_tlast), 32'd1);
    check("keep_err_pulse", 32'(bus.keep_error), 32'd1);
    tick();
    check("keep_err_clear", 32'(bus.keep_error), 32'd0);
    check("keep_no_upper", 32'(bus.tx_tvalid), 32'd0);
    check("keep_consumed3", 32'(bus.consumed_idx[3]), 32'd1);

    // Null beat yields nothing
    drive(1'b1, 32'h1234_5678, 4'h0, 1'b1, 2'd1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    check("null_valid", 32'(bus.tx_tvalid), 32'd0);
    check("null_rx_ready", 32'(bus.rx_tready), 32'd1);

    // Stall with a full buffer, then reset mid-stall
    bus.tx_tready = 1'b0;
    drive(1'b1, 32'h0022_0011, 4'hF, 1'b0, 2'd1);
    tick();
    drive(1'b1, 32'h0044_0033, 4'hF, 1'b0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_data_%0d", i), 32'(bus.tx_tdata), 32'h0011);
      check($sformatf("stall_valid_%0d", i), 32'(bus.tx_tvalid), 32'd1);
      check($sformatf("stall_rx_ready_%0d", i), 32'(bus.rx_tready), 32'd0);
      tick();
    end
    check("pre_rst_consumed1", 32'(bus.consumed_idx[1]), 32'd2);
    areset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.tx_tvalid), 32'd0);
    check("mid_rst_data", 32'(bus.tx_tdata), 32'd0);
    check("mid_rst_rx_ready", 32'(bus.rx_tready), 32'd0);
    check("mid_rst_consumed1", 32'(bus.consumed_idx[1]), 32'd0);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    bus.tx_tready = 1'b1;
    tick();
    areset_n = 1'b1;
    tick();
    tick();
    check("post_rst_discard", 32'(bus.tx_tvalid), 32'd0);

    // Counter wrap on queue 0
    drive(1'b1, 32'h0000_0042, 4'h3, 1'b0, 2'd0);
    repeat (65535) tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    tick();
    check("wrap_ffff", 32'(bus.consumed_idx[0]), 32'hFFFF);
    drive(1'b1, 32'h0000_0043, 4'h3, 1'b0, 2'd0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 2'd0);
    tick();
    check("wrap_zero", 32'(bus.consumed_idx[0]), 32'h0000);
    check("wrap_other_q", 32'(bus.consumed_idx[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
